alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
- Registered EX->MEM boundary stage consuming the 16-bit result of the execute-stage logic units (OR16/AND16/XOR16/adder result mux) together with destination-register metadata.
- Two-entry skid buffer with valid/ready handshake on both sides, synchronous flush for branch mispredict, and a Z/N flag register updated as results are accepted.
- Downstream consumer is the memory/writeback stage.

Parameters:
- DW, 16, result datapath width.
- RW, 4, destination register index width.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- in_valid  input  1  upstream has a result this cycle.
- in_ready  output  1  stage can accept; registered, equals ~skid_valid.
- in_result  input  DW  ALU result (e.g. OR16 output).
- in_dst  input  RW  destination register index.
- in_wen  input  1  result is written back.
- in_setf  input  1  instruction updates Z/N flags.
- flush  input  1  discard all held entries.
- out_valid  output  1  main entry valid.
- out_ready  input  1  downstream accepts main entry.
- out_result  output  DW  main entry result.
- out_dst  output  RW  main entry destination.
- out_wen  output  1  main entry write enable, gated by out_valid.
- flag_z  output  1  zero flag.
- flag_n  output  1  negative flag (result MSB).
- occupancy  output  2  held entries, 0..2.

Behaviour:
- Reset (rst_n=0 at edge): main_valid=0, skid_valid=0, out_result=0, out_dst=0, out_wen=0, flag_z=0, flag_n=0, occupancy=0, in_ready=1. Reset overrides flush and all handshakes.
- Accept = in_valid & in_ready. Release = out_valid & out_ready. Both evaluated on the same edge.
- State by (main_valid, skid_valid): EMPTY(0,0), ONE(1,0), FULL(1,1); (0,1) unreachable.
- EMPTY: accept -> ONE, entry loads main.
- ONE: accept & release -> ONE, new entry loads main. Accept & ~release -> FULL, new entry loads skid. ~accept & release -> EMPTY. Neither -> hold.
- FULL: in_ready=0, so no accept. Release -> ONE, skid moves into main. ~release -> hold.
- Latency: 1 cycle from accept to out_valid when the stage was EMPTY or draining. Order is strictly FIFO; no reordering.
- Throughput: 1 entry/cycle when out_ready is held high.
- Outputs come straight from the main register (no combinational in->out path). in_ready is a flop, so there is no combinational ready path.
- out_wen = main_wen & main_valid.
- Flush=1 at an edge:
  - main_valid and skid_valid go to 0, and occupancy goes to 0.
  - An accept in the same cycle is dropped.
  - Flags do not update from that dropped entry.
  - A release in the same cycle still counts as consumed downstream.
- Flags:
  - On accept with in_setf=1 and flush=0: flag_z <= (in_result==0) and flag_n <= in_result[DW-1].
  - Flags hold otherwise.
  - Flags are not rolled back by a later flush.
- occupancy = main_valid + skid_valid, registered.
- Data registers of invalid entries may hold stale values. Only the valid bits are contractual, except at reset, where all are zeroed.

Test Plan:
- Reset then streaming: rst_n=0 for 2 cycles, then in_valid=1 with results 0x00F0, 0x0F00, 0xF000 on consecutive cycles, out_ready=1 -> out_result shows 0x00F0, 0x0F00, 0xF000 on cycles 1, 2, 3 after the first accept; in_ready stays 1; occupancy stays 1.
- Backpressure fill: out_ready=0, send 0x1111 then 0x2222 -> occupancy 2, in_ready=0; a third 0x3333 is held by upstream. Raise out_ready -> outputs 0x1111, 0x2222, 0x3333 in order, with no loss or duplication.
- Flags: accept 0x0000 with in_setf=1 -> flag_z=1, flag_n=0. Accept 0x8001 with in_setf=0 -> flags unchanged. Accept 0x8001 with in_setf=1 -> flag_z=0, flag_n=1.
- Flush when FULL: hold 0xAAAA and 0x5555, assert flush together with in_valid carrying 0x0000 and in_setf=1 -> next cycle out_valid=0, occupancy=0, in_ready=1, flag_z unchanged.
- Simultaneous accept/release in ONE: main holds 0x0001, out_ready=1, in 0x0002 -> next cycle out_result=0x0002, occupancy=1.
- Reset mid-operation: with occupancy=2 and flags set, drive rst_n=0 for one edge together with in_valid=1 -> all outputs zero, in_ready=1, and the incoming entry is not captured.

Source files
------------

// File: rtl/alu_result_stage_if.sv
// Handshake and status bundle between the execute units, the EX->MEM result stage and the memory/writeback stage.
// The stage connects through "slave"; whoever drives it (pipeline or bench) uses "master".
interface alu_result_stage_if #(
   parameter int DW = 16,
   parameter int RW = 4
);
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_result;
   logic [RW-1:0] in_dst;
   logic          in_wen;
   logic          in_setf;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_result;
   logic [RW-1:0] out_dst;
   logic          out_wen;
   logic          flag_z;
   logic          flag_n;
   logic [1:0]    occupancy;

   modport slave (
      input  in_valid, in_result, in_dst, in_wen, in_setf, flush, out_ready,
      output in_ready, out_valid, out_result, out_dst, out_wen, flag_z, flag_n, occupancy
   );

   modport master (
      output in_valid, in_result, in_dst, in_wen, in_setf, flush, out_ready,
      input  in_ready, out_valid, out_result, out_dst, out_wen, flag_z, flag_n, occupancy
   );
endinterface

// File: rtl/alu_result_stage.sv
// EX->MEM result register with a two-entry skid buffer and Z/N flags; 1-cycle accept-to-output latency.
// in_ready is registered and drops only when the skid entry is occupied; flush empties both entries.
module alu_result_stage #(
   parameter int DW = 16,
   parameter int RW = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   alu_result_stage_if.slave  bus
);

   typedef struct packed {
      logic [DW-1:0] result;
      logic [RW-1:0] dst;
      logic          wen;
   } entry_t;

   // Bit 0 is main_valid, bit 1 is skid_valid; 2'b10 is unreachable.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      FULL  = 2'b11
   } state_t;

   state_t     state_q, state_d;
   entry_t     main_q, skid_q, in_entry;
   logic       in_ready_q;
   logic [1:0] occ_q, occ_d;
   logic       flag_z_q, flag_n_q;
   logic       accept, release_main;
   logic       load_main, load_skid, skid_to_main;
   logic       set_flags;

   assign in_entry     = '{result: bus.in_result, dst: bus.in_dst, wen: bus.in_wen};
   assign accept       = bus.in_valid & in_ready_q;
   assign release_main = state_q[0] & bus.out_ready;
   assign set_flags    = accept & bus.in_setf & ~bus.flush;

   always_comb begin
      state_d      = state_q;
      load_main    = 1'b0;
      load_skid    = 1'b0;
      skid_to_main = 1'b0;
      occ_d        = 2'd0;
      unique case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d   = ONE;
               load_main = 1'b1;
            end
         end
         ONE: begin
            if (accept && release_main) begin
               load_main = 1'b1;
            end else if (accept) begin
               state_d   = FULL;
               load_skid = 1'b1;
            end else if (release_main) begin
               state_d   = EMPTY;
            end
         end
         FULL: begin
            if (release_main) begin
               state_d      = ONE;
               skid_to_main = 1'b1;
            end
         end
         default: state_d = EMPTY;
      endcase
      // Flush drops the same-cycle accept; a same-cycle release has already been taken downstream.
      if (bus.flush) begin
         state_d      = EMPTY;
         load_main    = 1'b0;
         load_skid    = 1'b0;
         skid_to_main = 1'b0;
      end
      case (state_d)
         ONE:     occ_d = 2'd1;
         FULL:    occ_d = 2'd2;
         default: occ_d = 2'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= EMPTY;
         main_q     <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b1;
         occ_q      <= 2'd0;
         flag_z_q   <= 1'b0;
         flag_n_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != FULL);
         occ_q      <= occ_d;
         if (load_main) begin
            main_q <= in_entry;
         end else if (skid_to_main) begin
            main_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= in_entry;
         end
         if (set_flags) begin
            flag_z_q <= (bus.in_result == '0);
            flag_n_q <= bus.in_result[DW-1];
         end
      end
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.out_valid  = state_q[0];
   assign bus.out_result = main_q.result;
   assign bus.out_dst    = main_q.dst;
   assign bus.out_wen    = main_q.wen & state_q[0];
   assign bus.flag_z     = flag_z_q;
   assign bus.flag_n     = flag_n_q;
   assign bus.occupancy  = occ_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: table of per-cycle vectors with expected state, plus a queue scoreboard.
module tb_alu_result_stage;

   logic clk;
   logic rst_n;

   alu_result_stage_if #(.DW(16), .RW(4)) bus ();

   alu_result_stage #(.DW(16), .RW(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] res;
      logic [3:0]  dst;
      logic        wen;
   } sb_t;

   typedef struct {
      logic        v;
      logic [15:0] res;
      logic [3:0]  dst;
      logic        wen;
      logic        setf;
      logic        fl;
      logic        ordy;
      logic [1:0]  e_occ;
      logic        e_ov;
      logic [15:0] e_res;
      logic        e_rdy;
      logic        e_z;
      logic        e_n;
   } vec_t;

   sb_t  sb[$];
   vec_t tbl[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   logic mz, mn;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic [15:0] r, input logic [3:0] d, input logic w,
                        input logic s, input logic f, input logic o);
      bus.in_valid  = v;
      bus.in_result = r;
      bus.in_dst    = d;
      bus.in_wen    = w;
      bus.in_setf   = s;
      bus.flush     = f;
      bus.out_ready = o;
   endtask

   // Scoreboard/flag model update from the values presented before the edge, then state checks after it.
   task automatic step();
      sb_t e;
      if (rst_n !== 1'b1) begin
         sb.delete();
         mz = 1'b0;
         mn = 1'b0;
      end else begin
         if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL sb_underflow: got a release, expected none at %0t", $time);
            end else begin
               e = sb.pop_front();
               check("sb_result", 32'(bus.out_result), 32'(e.res));
               check("sb_dst", 32'(bus.out_dst), 32'(e.dst));
               check("sb_wen", 32'(bus.out_wen), 32'(e.wen));
            end
         end
         if (bus.flush) begin
            sb.delete();
         end else if (bus.in_valid && bus.in_ready === 1'b1) begin
            sb.push_back('{res: bus.in_result, dst: bus.in_dst, wen: bus.in_wen});
            if (bus.in_setf) begin
               mz = (bus.in_result == 16'h0000);
               mn = bus.in_result[15];
            end
         end
      end
      @(posedge clk);
      #1;
      check("occupancy", 32'(bus.occupancy), 32'(sb.size()));
      check("out_valid", 32'(bus.out_valid), 32'(sb.size() != 0));
      check("in_ready", 32'(bus.in_ready), 32'(sb.size() < 2));
      check("flag_z", 32'(bus.flag_z), 32'(mz));
      check("flag_n", 32'(bus.flag_n), 32'(mn));
      if (bus.out_valid !== 1'b1) check("out_wen_gated", 32'(bus.out_wen), 32'd0);
   endtask

   task automatic add(input logic v, input logic [15:0] r, input logic [3:0] d, input logic w,
                      input logic s, input logic f, input logic o, input logic [1:0] eo,
                      input logic eov, input logic [15:0] er, input logic erdy,
                      input logic ez, input logic en);
      tbl.push_back('{v: v, res: r, dst: d, wen: w, setf: s, fl: f, ordy: o, e_occ: eo,
                      e_ov: eov, e_res: er, e_rdy: erdy, e_z: ez, e_n: en});
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
      check({tag, "_out_result"}, 32'(bus.out_result), 32'd0);
      check({tag, "_out_dst"}, 32'(bus.out_dst), 32'd0);
      check({tag, "_out_wen"}, 32'(bus.out_wen), 32'd0);
      check({tag, "_flag_z"}, 32'(bus.flag_z), 32'd0);
      check({tag, "_flag_n"}, 32'(bus.flag_n), 32'd0);
      check({tag, "_occupancy"}, 32'(bus.occupancy), 32'd0);
      check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      mz = 1'b0;
      mn = 1'b0;
      rst_n = 1'b0;
      drive(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);

      //    v     res       dst   wen   setf  fl    ordy  occ   ov    exp_res   rdy   z     n
      // streaming
      add(1'b1, 16'h00F0, 4'h1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 16'h00F0, 1'b1, 1'b0, 1'b0);
      add(1'b1, 16'h0F00, 4'h2, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 16'h0F00, 1'b1, 1'b0, 1'b0);
      add(1'b1, 16'hF000, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 16'hF000, 1'b1, 1'b0, 1'b0);
      add(1'b0, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      // backpressure fill and drain
      add(1'b1, 16'h1111, 4'h4, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 16'h1111, 1'b1, 1'b0, 1'b0);
      add(1'b1, 16'h2222, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 16'h1111, 1'b0, 1'b0, 1'b0);
      add(1'b1, 16'h3333, 4'h6, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 16'h1111, 1'b0, 1'b0, 1'b0);
      add(1'b1, 16'h3333, 4'h6, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 16'h2222, 1'b1, 1'b0, 1'b0);
      add(1'b1, 16'h3333, 4'h6, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 16'h3333, 1'b1, 1'b0, 1'b0);
      add(1'b0, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      // flags
      add(1'b1, 16'h0000, 4'h7, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);
      add(1'b1, 16'h8001, 4'h8, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 16'h8001, 1'b1, 1'b1, 1'b0);
      add(1'b1, 16'h8001, 4'h9, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 16'h8001, 1'b1, 1'b0, 1'b1);
      add(1'b0, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
      // flush while FULL, incoming zero result with setf must not touch flags
      add(1'b1, 16'hAAAA, 4'hA, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 16'hAAAA, 1'b1, 1'b0, 1'b1);
      add(1'b1, 16'h5555, 4'hB, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b1);
      add(1'b1, 16'h0000, 4'hC, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
      // flush in ONE with same-cycle release and accept
      add(1'b1, 16'h0007, 4'hD, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 16'h0007, 1'b1, 1'b0, 1'b1);
      add(1'b1, 16'h0000, 4'hE, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
      // simultaneous accept/release in ONE
      add(1'b1, 16'h0001, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b1);
      add(1'b1, 16'h0002, 4'h2, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b1);
      add(1'b0, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b1);

      step();
      step();
      check_zero("reset");
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         drive(tbl[i].v, tbl[i].res, tbl[i].dst, tbl[i].wen, tbl[i].setf, tbl[i].fl, tbl[i].ordy);
         step();
         check($sformatf("vec%0d_occ", i), 32'(bus.occupancy), 32'(tbl[i].e_occ));
         check($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(tbl[i].e_ov));
         if (tbl[i].e_ov) check($sformatf("vec%0d_out_result", i), 32'(bus.out_result), 32'(tbl[i].e_res));
         check($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'(tbl[i].e_rdy));
         check($sformatf("vec%0d_flag_z", i), 32'(bus.flag_z), 32'(tbl[i].e_z));
         check($sformatf("vec%0d_flag_n", i), 32'(bus.flag_n), 32'(tbl[i].e_n));
      end

      // Reset mid-operation: fill to two entries with Z set, then reset alongside a new input.
      drive(1'b1, 16'h0000, 4'h3, 1'b1, 1'b1, 1'b0, 1'b0);
      step();
      check("fill_occ", 32'(bus.occupancy), 32'd2);
      check("fill_flag_z", 32'(bus.flag_z), 32'd1);
      rst_n = 1'b0;
      drive(1'b1, 16'hBEEF, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0);
      step();
      check_zero("midrst");
      rst_n = 1'b1;
      drive(1'b0, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
      check("midrst_not_captured", 32'(bus.occupancy), 32'd0);

      // Random traffic against the scoreboard, then drain.
      for (int k = 0; k < 300; k++) begin
         drive(1'($urandom_range(0, 1)), 16'($urandom), 4'($urandom), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0));
         step();
      end
      drive(1'b0, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 4; k++) step();
      check("drain_empty", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
